fx2_if: RTL and testbench

//  Cypress FX2LP slave-FIFO bridge in synchronous mode (IFCLK driven by the FX2).

---
 rtl/fx2_if.sv | 91 +++++++++
 tb/tb_fx2_if.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fx2_if.sv
// FX2LP synchronous slave-FIFO bridge: drains the OUT-endpoint FIFO over FD and
// presents each word on data_out with a one-cycle active-low valid strobe.
module fx2_if #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  ifclk,
    input  logic                  rst,
    inout  wire  [DATA_WIDTH-1:0] fd,
    input  logic                  ef_n,
    input  logic                  ff_n,
    output logic                  slrd_n,
    output logic                  slwr_n,
    output logic                  sloe_n,
    output logic                  pktend_n,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid_n
);

    typedef enum logic [1:0] {
        IDLE,
        OE,
        READ
    } state_t;

    state_t                  state_q, state_d;
    logic                    sloe_n_q, sloe_n_d;
    logic                    slrd_n_q, slrd_n_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    data_valid_n_q, data_valid_n_d;

    // Write path is idle; the full flag has no consumer.
    logic unused_ff_n;
    assign unused_ff_n = ff_n;

    always_comb begin
        state_d        = state_q;
        sloe_n_d       = 1'b1;
        slrd_n_d       = 1'b1;
        data_out_d     = data_out_q;
        data_valid_n_d = 1'b1;

        // The word on FD at a strobed edge is captured even if ef_n drops at that edge.
        if (!slrd_n_q) begin
            data_out_d     = fd;
            data_valid_n_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (ef_n) begin
                    state_d  = OE;
                    sloe_n_d = 1'b0;
                end
            end
            OE, READ: begin
                if (ef_n) begin
                    state_d  = READ;
                    sloe_n_d = 1'b0;
                    slrd_n_d = 1'b0;
                end else begin
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ifclk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            sloe_n_q       <= 1'b1;
            slrd_n_q       <= 1'b1;
            data_out_q     <= '0;
            data_valid_n_q <= 1'b1;
        end else begin
            state_q        <= state_d;
            sloe_n_q       <= sloe_n_d;
            slrd_n_q       <= slrd_n_d;
            data_out_q     <= data_out_d;
            data_valid_n_q <= data_valid_n_d;
        end
    end

    assign sloe_n       = sloe_n_q;
    assign slrd_n       = slrd_n_q;
    assign data_out     = data_out_q;
    assign data_valid_n = data_valid_n_q;
    assign slwr_n       = 1'b1;
    assign pktend_n     = 1'b1;

endmodule

// File: tb/tb_fx2_if.sv
// Directed bench for fx2_if with a simple FX2 FIFO model that drives an
// incrementing word on FD whenever the bridge enables the bus.
module tb_fx2_if;

    localparam int unsigned DW = 16;

    logic          ifclk = 1'b0;
    logic          rst   = 1'b1;
    logic          ef_n  = 1'b0;
    logic          ff_n  = 1'b0;
    wire  [DW-1:0] fd;
    logic          slrd_n, slwr_n, sloe_n, pktend_n, data_valid_n;
    logic [DW-1:0] data_out;

    logic [DW-1:0] fx2_cnt;
    int            checks = 0;
    int            errors = 0;
    int            static_err = 0;

    always #15 ifclk = ~ifclk;

    fx2_if #(.DATA_WIDTH(DW)) dut (
        .ifclk        (ifclk),
        .rst          (rst),
        .fd           (fd),
        .ef_n         (ef_n),
        .ff_n         (ff_n),
        .slrd_n       (slrd_n),
        .slwr_n       (slwr_n),
        .sloe_n       (sloe_n),
        .pktend_n     (pktend_n),
        .data_out     (data_out),
        .data_valid_n (data_valid_n)
    );

    // FX2 model: FIFO pointer advances on every strobed edge; FD driven only while enabled.
    always @(posedge ifclk or posedge rst) begin
        if (rst) fx2_cnt <= '0;
        else if (!slrd_n) fx2_cnt <= fx2_cnt + 1'b1;
    end
    assign fd = (!sloe_n) ? fx2_cnt : 'z;

    // Whole-run watch on the bus and the idle write-path outputs.
    always @(negedge ifclk) begin
        if (slwr_n !== 1'b1 || pktend_n !== 1'b1) static_err++;
        if (sloe_n === 1'b1 && fd !== {DW{1'bz}}) static_err++;
        if (sloe_n === 1'b0 && fd !== fx2_cnt) static_err++;
    end

    task automatic test_reset();
        rst = 1'b1; ef_n = 1'b0;
        repeat (2) @(negedge ifclk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ifclk);
            checks++;
            if ({slrd_n, sloe_n, slwr_n, pktend_n, data_valid_n, data_out} !== {5'b11111, 16'h0000}) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%b_%h exp=11111_0000", i,
                         {slrd_n, sloe_n, slwr_n, pktend_n, data_valid_n}, data_out);
            end
        end
    endtask

    task automatic test_startup();
        ef_n = 1'b1;
        @(negedge ifclk);
        checks++;
        if ({sloe_n, slrd_n} !== 2'b01) begin
            errors++; $display("FAIL startup_oe got sloe/slrd=%b exp=01", {sloe_n, slrd_n});
        end
        @(negedge ifclk);
        checks++;
        if ({sloe_n, slrd_n, data_valid_n} !== 3'b001) begin
            errors++; $display("FAIL startup_rd got sloe/slrd/vld=%b exp=001", {sloe_n, slrd_n, data_valid_n});
        end
        @(negedge ifclk);
        checks++;
        if (data_valid_n !== 1'b0 || data_out !== 16'd0) begin
            errors++; $display("FAIL startup_word0 got vld=%b data=%0d exp vld=0 data=0", data_valid_n, data_out);
        end
    endtask

    task automatic test_stop_restart();
        ef_n = 1'b0;
        @(negedge ifclk);
        checks++;
        if ({slrd_n, sloe_n, data_valid_n} !== 3'b110 || data_out !== 16'd1) begin
            errors++; $display("FAIL stop_inflight got slrd/sloe/vld=%b data=%0d exp=110 data=1",
                               {slrd_n, sloe_n, data_valid_n}, data_out);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge ifclk);
            checks++;
            if (data_valid_n !== 1'b1 || slrd_n !== 1'b1 || data_out !== 16'd1) begin
                errors++; $display("FAIL stop_quiet cyc=%0d got vld=%b slrd=%b data=%0d exp vld=1 slrd=1 data=1",
                                   i, data_valid_n, slrd_n, data_out);
            end
        end
        ef_n = 1'b1;
        @(negedge ifclk);
        checks++;
        if ({sloe_n, slrd_n, data_valid_n} !== 3'b011) begin
            errors++; $display("FAIL restart_oe got sloe/slrd/vld=%b exp=011", {sloe_n, slrd_n, data_valid_n});
        end
        @(negedge ifclk);
        checks++;
        if (slrd_n !== 1'b0) begin
            errors++; $display("FAIL restart_rd got slrd=%b exp=0", slrd_n);
        end
        @(negedge ifclk);
        ef_n = 1'b0;
        checks++;
        if (data_valid_n !== 1'b0 || data_out !== 16'd2) begin
            errors++; $display("FAIL restart_word2 got vld=%b data=%0d exp vld=0 data=2", data_valid_n, data_out);
        end
        @(negedge ifclk);
        checks++;
        if (data_valid_n !== 1'b0 || data_out !== 16'd3 || slrd_n !== 1'b1) begin
            errors++; $display("FAIL restart_word3 got vld=%b slrd=%b data=%0d exp vld=0 slrd=1 data=3",
                               data_valid_n, slrd_n, data_out);
        end
        @(negedge ifclk);
        checks++;
        if (data_valid_n !== 1'b1) begin
            errors++; $display("FAIL restart_end got vld=%b exp=1", data_valid_n);
        end
    endtask

    task automatic test_stream();
        logic [3:0]    cnt4;
        logic [DW-1:0] exp_word;
        int            pulses, strobes;
        cnt4 = '0; exp_word = '0; pulses = 0; strobes = 0;
        rst = 1'b1; ef_n = 1'b0;
        @(negedge ifclk);
        rst = 1'b0;
        for (int i = 0; i < 104; i++) begin
            if (!data_valid_n) begin
                pulses++;
                checks++;
                if (data_out !== exp_word) begin
                    errors++; $display("FAIL stream_seq pulse=%0d got=%0d exp=%0d", pulses, data_out, exp_word);
                end
                exp_word = data_out + 1'b1;
            end
            if (!slrd_n) strobes++;
            ef_n = (i < 100) ? (cnt4 > 4'd4) : 1'b0;
            cnt4 = cnt4 + 1'b1;
            @(negedge ifclk);
        end
        checks++;
        if (pulses !== strobes) begin
            errors++; $display("FAIL stream_count got pulses=%0d exp strobes=%0d", pulses, strobes);
        end
        checks++;
        if (pulses < 40) begin
            errors++; $display("FAIL stream_volume got pulses=%0d exp >=40", pulses);
        end
    endtask

    task automatic test_reset_in_read();
        int waited;
        waited = 0;
        ef_n = 1'b1;
        while (data_valid_n !== 1'b0 && waited < 10) begin
            @(negedge ifclk);
            waited++;
        end
        checks++;
        if (data_valid_n !== 1'b0) begin
            errors++; $display("FAIL rstread_reach got vld=%b exp=0 within 10 cycles", data_valid_n);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({slrd_n, sloe_n, data_valid_n} !== 3'b111 || data_out !== 16'd0) begin
            errors++; $display("FAIL rstread_async got slrd/sloe/vld=%b data=%0d exp=111 data=0",
                               {slrd_n, sloe_n, data_valid_n}, data_out);
        end
        @(negedge ifclk);
        rst = 1'b0;
        @(negedge ifclk);
        checks++;
        if ({sloe_n, slrd_n, data_valid_n} !== 3'b011) begin
            errors++; $display("FAIL rstread_oe got sloe/slrd/vld=%b exp=011", {sloe_n, slrd_n, data_valid_n});
        end
        @(negedge ifclk);
        @(negedge ifclk);
        ef_n = 1'b0;
        checks++;
        if (data_valid_n !== 1'b0 || data_out !== 16'd0) begin
            errors++; $display("FAIL rstread_word0 got vld=%b data=%0d exp vld=0 data=0", data_valid_n, data_out);
        end
        repeat (3) @(negedge ifclk);
    endtask

    task automatic test_static();
        for (int i = 0; i < 24; i++) begin
            ff_n = 1'($urandom_range(1));
            ef_n = (i % 8) < 5;
            @(negedge ifclk);
            checks++;
            if (slwr_n !== 1'b1 || pktend_n !== 1'b1) begin
                errors++; $display("FAIL static_wr cyc=%0d got slwr=%b pktend=%b exp 1 1", i, slwr_n, pktend_n);
            end
        end
        ef_n = 1'b0;
        repeat (3) @(negedge ifclk);
        checks++;
        if (static_err !== 0) begin
            errors++; $display("FAIL static_bus got violations=%0d exp=0", static_err);
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_stop_restart();
        test_stream();
        test_reset_in_read();
        test_static();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
